// File: rtl/memory_game_pkg.sv
// Shared definitions for the memory game: note and level geometry, the recorder
// state encoding (4 bits wide so it can drive a hex digit directly), and a helper
// that locates a note slot inside a packed level word.
package memory_game_pkg;

  localparam int REC_NOTE_W    = 4;  // one bit per key
  localparam int REC_MAX_NOTES = 4;  // default notes per level
  localparam int REC_LEN_W     = 4;  // level_length width, holds up to 15

  typedef enum logic [3:0] {
    REC_IDLE         = 4'd0,
    REC_WAIT_PRESS   = 4'd1,
    REC_DEBOUNCE     = 4'd2,
    REC_WAIT_RELEASE = 4'd3,
    REC_DONE         = 4'd4
  } rec_state_e;

  // Bit position of the LSB of slot idx. Note 0 lives in the top bits of the word.
  function automatic int slot_lsb(int max_notes, int note_w, logic [REC_LEN_W-1:0] idx);
    return (max_notes - 1 - int'(idx)) * note_w;
  endfunction

endpackage

// File: rtl/note_recorder_if.sv
// Bus between the recorder and its user (game_core or a bench).
// master: drives keys and start/finish pulses, reads the level word and status.
// slave:  the recorder itself.
interface note_recorder_if
  import memory_game_pkg::*;
#(
  parameter int MAX_NOTES = REC_MAX_NOTES,
  parameter int NOTE_W    = REC_NOTE_W
) ();

  logic [NOTE_W-1:0]           note_inputs;
  logic                        start_record;
  logic                        finish_record;
  logic [MAX_NOTES*NOTE_W-1:0] level_data;
  logic [REC_LEN_W-1:0]        level_length;
  logic                        recording;
  logic                        note_valid;
  logic [NOTE_W-1:0]           note_value;
  logic                        done_record;

  modport master (
    output note_inputs, start_record, finish_record,
    input  level_data, level_length, recording, note_valid, note_value, done_record
  );

  modport slave (
    input  note_inputs, start_record, finish_record,
    output level_data, level_length, recording, note_valid, note_value, done_record
  );

endinterface

// File: rtl/key_debouncer.sv
// Key pattern debouncer: latches the first nonzero pattern, re-latches on any change
// to another nonzero pattern, drops on a return to zero, and flags stable_vld in the
// cycle the pattern has been seen on DEBOUNCE_CYCLES+1 consecutive edges.
// Ports: clk, reset (async, high), clr (drop any tracked pattern), pat_in (keys),
// stable_vld / stable_dat (accepted pattern), released (keys currently all up).
module key_debouncer #(
  parameter int NOTE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [NOTE_W-1:0] pat_in,
  output logic              stable_vld,
  output logic [NOTE_W-1:0] stable_dat,
  output logic              released
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NOTE_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tracking;

  // The latch edge itself counts as the first stable sample, so the count only
  // needs to reach DEBOUNCE_CYCLES-1 before the next matching edge accepts it.
  assign tracking   = (pat_q != '0);
  assign stable_vld = tracking && (pat_in == pat_q) && (cnt_q == CNT_LAST);
  assign stable_dat = pat_q;
  assign released   = (pat_in == '0);

  always_comb begin
    pat_d = pat_q;
    cnt_d = cnt_q;
    if (clr) begin
      pat_d = '0;
      cnt_d = '0;
    end else if (!tracking) begin
      pat_d = pat_in;  // stays idle when pat_in is zero
      cnt_d = '0;
    end else if (released || stable_vld) begin
      pat_d = '0;
      cnt_d = '0;
    end else if (pat_in != pat_q) begin
      pat_d = pat_in;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= '0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_recorder.sv
// Level recorder: debounces key presses and packs each captured note MSB-first into
// level_data (note 0 in the top NOTE_W bits), ending on buffer full or finish_record.
// Ports: clk, reset (async, high), rec (note_recorder_if.slave: keys, start/finish
// pulses in; level_data, level_length, recording, note_valid/note_value, done_record out).
// Optional macro RECORD_TIMEOUT_EN: auto-finish after TIMEOUT_CYCLES idle in WAIT_PRESS.
module note_recorder
  import memory_game_pkg::*;
#(
  parameter int MAX_NOTES       = REC_MAX_NOTES,
  parameter int NOTE_W          = REC_NOTE_W,
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = 8
) (
  input  logic           clk,
  input  logic           reset,
  note_recorder_if.slave rec
);

  localparam int                   DATA_W  = MAX_NOTES * NOTE_W;
  localparam logic [REC_LEN_W-1:0] MAX_LEN = REC_LEN_W'(MAX_NOTES);

  rec_state_e           state_q, state_d;
  logic [DATA_W-1:0]    level_data_q, level_data_d;
  logic [REC_LEN_W-1:0] level_length_q, level_length_d;
  logic                 recording_q, recording_d;
  logic                 note_valid_q, note_valid_d;
  logic [NOTE_W-1:0]    note_value_q, note_value_d;
  logic                 done_record_q, done_record_d;
  logic                 fin_pend_q, fin_pend_d;  // finish seen while a note was in flight

  logic                 db_clr, db_stable_vld, db_released;
  logic [NOTE_W-1:0]    db_stable_dat;
  logic                 fin_eff, have_notes;

`ifdef RECORD_TIMEOUT_EN
  localparam int            IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  key_debouncer #(
    .NOTE_W          (NOTE_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk        (clk),
    .reset      (reset),
    .clr        (db_clr),
    .pat_in     (rec.note_inputs),
    .stable_vld (db_stable_vld),
    .stable_dat (db_stable_dat),
    .released   (db_released)
  );

  always_comb begin
    state_d        = state_q;
    level_data_d   = level_data_q;
    level_length_d = level_length_q;
    note_valid_d   = 1'b0;
    note_value_d   = note_value_q;
    fin_pend_d     = fin_pend_q;
    fin_eff        = fin_pend_q | rec.finish_record;
    have_notes     = (level_length_q != '0);
`ifdef RECORD_TIMEOUT_EN
    idle_d         = '0;
`endif

    // start_record restarts from any state and outranks a simultaneous finish.
    if (rec.start_record) begin
      state_d        = REC_WAIT_PRESS;
      level_data_d   = '0;
      level_length_d = '0;
      fin_pend_d     = 1'b0;
    end else begin
      unique case (state_q)
        REC_IDLE: ;
        REC_WAIT_PRESS: begin
          fin_pend_d = 1'b0;
          if (rec.finish_record && have_notes) begin
            state_d = REC_DONE;
          end else if (!db_released) begin
            state_d = REC_DEBOUNCE;
          end else begin
`ifdef RECORD_TIMEOUT_EN
            // Saturates with an empty buffer so an idle empty recording never ends.
            idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_W'(1);
            if ((idle_d == IDLE_MAX) && have_notes) state_d = REC_DONE;
`endif
          end
        end
        REC_DEBOUNCE: begin
          fin_pend_d = fin_eff;
          if (db_stable_vld) begin
            // Slot level_length is still zero (cleared at start), so OR-in is a write.
            if (level_length_q < MAX_LEN) begin
              level_data_d   = level_data_q |
                               (DATA_W'(db_stable_dat) << slot_lsb(MAX_NOTES, NOTE_W, level_length_q));
              level_length_d = level_length_q + REC_LEN_W'(1);
            end
            note_valid_d = 1'b1;
            note_value_d = db_stable_dat;
            state_d      = REC_WAIT_RELEASE;
          end else if (db_released) begin
            // Glitch: nothing captured; a pending finish takes effect now if possible.
            fin_pend_d = 1'b0;
            state_d    = (fin_eff && have_notes) ? REC_DONE : REC_WAIT_PRESS;
          end
        end
        REC_WAIT_RELEASE: begin
          fin_pend_d = fin_eff;
          if (db_released) begin
            fin_pend_d = 1'b0;
            state_d    = (fin_eff || (level_length_q == MAX_LEN)) ? REC_DONE : REC_WAIT_PRESS;
          end
        end
        REC_DONE: state_d = REC_IDLE;
        default:  state_d = REC_IDLE;
      endcase
    end

    done_record_d = (state_d == REC_DONE);
    recording_d   = (state_d == REC_WAIT_PRESS) || (state_d == REC_DEBOUNCE) ||
                    (state_d == REC_WAIT_RELEASE);
    // The debouncer only tracks while a press is awaited; a restart drops any latch.
    db_clr        = rec.start_record ||
                    !((state_d == REC_WAIT_PRESS) || (state_d == REC_DEBOUNCE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= REC_IDLE;
      level_data_q   <= '0;
      level_length_q <= '0;
      recording_q    <= 1'b0;
      note_valid_q   <= 1'b0;
      note_value_q   <= '0;
      done_record_q  <= 1'b0;
      fin_pend_q     <= 1'b0;
`ifdef RECORD_TIMEOUT_EN
      idle_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      level_data_q   <= level_data_d;
      level_length_q <= level_length_d;
      recording_q    <= recording_d;
      note_valid_q   <= note_valid_d;
      note_value_q   <= note_value_d;
      done_record_q  <= done_record_d;
      fin_pend_q     <= fin_pend_d;
`ifdef RECORD_TIMEOUT_EN
      idle_q         <= idle_d;
`endif
    end
  end

  assign rec.level_data   = level_data_q;
  assign rec.level_length = level_length_q;
  assign rec.recording    = recording_q;
  assign rec.note_valid   = note_valid_q;
  assign rec.note_value   = note_value_q;
  assign rec.done_record  = done_record_q;

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: directed scenarios plus random key/start/finish traffic,
// checked by a scoreboard fed from a behavioural model of the recording rules.
module tb_note_recorder;

  localparam int MAXN = 4;
  localparam int W    = 4;
  localparam int D    = 2;
  localparam int T    = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  note_recorder_if #(.MAX_NOTES(MAXN), .NOTE_W(W)) bus ();

  note_recorder #(
    .MAX_NOTES(MAXN), .NOTE_W(W), .DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rec   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit          is_done;
    logic [W-1:0] val;
    logic [15:0] data;
    int          len;
  } ev_t;
  ev_t exp_q[$];

  // Model state: recording flag, whether a new press is awaited, length of the
  // current run of identical nonzero samples, pending finish, idle count, notes.
  bit          m_rec, m_armed, m_pend;
  int          m_run, m_idle;
  logic [W-1:0] m_pat;
  logic [W-1:0] m_notes[$];

  function automatic logic [15:0] pack_notes();
    logic [15:0] d = '0;
    for (int i = 0; i < MAXN; i++)
      d = {d[11:0], (i < m_notes.size()) ? m_notes[i] : 4'h0};
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rec = 0; m_armed = 0; m_pend = 0; m_run = 0; m_idle = 0; m_pat = '0;
    m_notes.delete();
    exp_q.delete();
  endtask

  task automatic finish_model();
    ev_t e;
    m_rec = 0;
    e.is_done = 1; e.val = '0; e.data = pack_notes(); e.len = m_notes.size();
    exp_q.push_back(e);
  endtask

  task automatic model_step(input logic [W-1:0] in, input bit st, input bit fin);
    ev_t e;
    bit  go_done;
    go_done = 0;
    if (st) begin
      m_rec = 1; m_armed = 1; m_run = 0; m_pend = 0; m_idle = 0;
      m_notes.delete();
    end else if (m_rec) begin
      if (m_armed && m_run == 0) begin
        if (fin && m_notes.size() > 0) go_done = 1;
        else if (in != 0) begin m_pat = in; m_run = 1; m_idle = 0; end
        else begin
`ifdef RECORD_TIMEOUT_EN
          if (m_idle < T) m_idle++;
          if (m_idle == T && m_notes.size() > 0) go_done = 1;
`endif
        end
      end else if (m_armed) begin
        if (fin) m_pend = 1;
        if (in == 0) begin
          m_run = 0; m_idle = 0;
          if (m_pend && m_notes.size() > 0) go_done = 1;
          m_pend = 0;
        end else if (in != m_pat) begin
          m_pat = in; m_run = 1;
        end else begin
          m_run++;
          if (m_run == D + 1) begin
            m_notes.push_back(m_pat);
            e.is_done = 0; e.val = m_pat; e.data = pack_notes(); e.len = m_notes.size();
            exp_q.push_back(e);
            m_armed = 0; m_run = 0;
          end
        end
      end else begin
        if (fin) m_pend = 1;
        if (in == 0) begin
          if (m_pend || m_notes.size() == MAXN) go_done = 1;
          else m_armed = 1;
          m_pend = 0; m_idle = 0;
        end
      end
      if (go_done) finish_model();
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, settle.
  task automatic step(input logic [W-1:0] in, input bit st, input bit fin);
    bus.note_inputs   = in;
    bus.start_record  = st;
    bus.finish_record = fin;
    @(posedge clk);
    model_step(in, st, fin);
    #1;
  endtask

  task automatic press(input logic [W-1:0] p, input int hold);
    for (int k = 0; k < hold; k++) step(p, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
  endtask

  // Monitor: status checked every cycle, events popped whenever the DUT pulses.
  always @(negedge clk) begin
    if (!reset) begin
      ev_t e;
      chk("recording", bus.recording, m_rec);
      chk("level_length", bus.level_length, m_notes.size());
      chk("level_data", bus.level_data, pack_notes());
      if (bus.note_valid || bus.done_record) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_event: note_valid=%0b done_record=%0b expected none at %0t",
                   bus.note_valid, bus.done_record, $time);
        end else begin
          e = exp_q.pop_front();
          chk("event_note_valid", bus.note_valid, !e.is_done);
          chk("event_done_record", bus.done_record, e.is_done);
          if (!e.is_done) chk("note_value", bus.note_value, e.val);
          chk("event_level_data", bus.level_data, e.data);
          chk("event_level_length", bus.level_length, e.len);
        end
      end
      chk("missing_event", exp_q.size(), 0);
    end
  end

  int          r, h;
  logic [W-1:0] p;

  initial begin
    reset = 1'b1;
    bus.note_inputs = '0; bus.start_record = 0; bus.finish_record = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level_data", bus.level_data, 0);
    chk("rst_level_length", bus.level_length, 0);
    chk("rst_recording", bus.recording, 0);
    chk("rst_note_valid", bus.note_valid, 0);
    chk("rst_note_value", bus.note_value, 0);
    chk("rst_done_record", bus.done_record, 0);
    reset = 1'b0;

    // Full sequence fills the buffer.
    step(0, 1, 0);
    press(4'b0001, 4); press(4'b0010, 4); press(4'b0100, 4); press(4'b1000, 4);
    chk("full_data", bus.level_data, 16'h1248);
    chk("full_length", bus.level_length, 4);
    press(4'b0001, 4);  // ignored after full
    chk("full_ignored", bus.level_length, 4);

    // Glitch shorter than the debounce window.
    step(0, 1, 0);
    step(4'b0010, 0, 0);
    repeat (3) step(0, 0, 0);
    chk("glitch_length", bus.level_length, 0);

    // Finish with no notes is ignored; early finish after two notes.
    step(0, 0, 1);
    chk("fin_empty_recording", bus.recording, 1);
    press(4'b0100, 4); press(4'b0001, 3);
    step(0, 0, 1);
    chk("early_data", bus.level_data, 16'h4100);
    chk("early_length", bus.level_length, 2);
    step(0, 0, 0);

    // Restart mid-recording, then start+finish together.
    step(0, 1, 0);
    press(4'b1000, 4);
    step(0, 1, 0);
    chk("restart_data", bus.level_data, 0);
    chk("restart_recording", bus.recording, 1);
    step(0, 1, 1);
    chk("start_wins", bus.recording, 1);

`ifdef RECORD_TIMEOUT_EN
    press(4'b0010, 4);
    repeat (T + 2) step(0, 0, 0);
    chk("timeout_data", bus.level_data, 16'h2000);
    chk("timeout_recording", bus.recording, 0);
`endif

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) step(0, 1, 0);
      else if (r < 9) step(0, 0, 1);
      else if (r < 11) step(0, 1, 1);
      else if (r < 20) step(0, 0, 0);
      else begin
        p = 4'($urandom_range(0, 15));
        h = $urandom_range(1, 5);
        for (int k = 0; k < h; k++) step(p, 0, ($urandom_range(0, 30) == 0));
      end
    end
    repeat (4) step(0, 0, 0);

    // Asynchronous reset mid-record.
    step(0, 1, 0);
    press(4'b0001, 3); press(4'b0010, 3);
    step(4'b0100, 0, 0);
    #1 reset = 1'b1;
    #1;
    chk("areset_level_data", bus.level_data, 0);
    chk("areset_level_length", bus.level_length, 0);
    chk("areset_recording", bus.recording, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) step(0, 0, 0);

    chk("leftover_events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
